mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, sets the memory word address width; the memory holds 2**ADDR_WIDTH 16-bit words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a_req  input  1  port A (instruction fetch) read request, held until a_gnt.
REQ-005 a_addr  input  ADDR_WIDTH  port A word address, held until a_gnt.
REQ-006 a_gnt  output  1  port A request accepted this cycle.
REQ-007 a_rvalid  output  1  port A read data valid.
REQ-008 a_rdata  output  16  port A read data.
REQ-009 b_req  input  1  port B (data load/store) request, held until b_gnt.
REQ-010 b_we  input  1  port B write (1) or read (0).
REQ-011 b_addr  input  ADDR_WIDTH  port B word address.
REQ-012 b_wdata  input  16  port B write data.
REQ-013 b_gnt  output  1  port B request accepted this cycle.
REQ-014 b_rvalid  output  1  port B read data valid.
REQ-015 b_rdata  output  16  port B read data.
REQ-016 mem_addr  output  ADDR_WIDTH  to memory addr (memory registers it on clk).
REQ-017 mem_data  output  16  to memory write data.
REQ-018 mem_memw  output  1  to memory write enable.
REQ-019 mem_q  input  16  from memory; valid the cycle after its address is presented.

Function
REQ-020 Grant is combinational from requests and the priority state; at most one of a_gnt/b_gnt is high in any cycle.
REQ-021 A lone request is granted in the same cycle it is asserted; no idle bubble between back-to-back grants.
REQ-022 mem_addr equals the granted port's address; with no grant it is 0.
REQ-023 mem_memw = b_gnt & b_we; mem_data = b_wdata when b_gnt, else 0.
REQ-024 A register rsel (NONE/A/B) loads, at the rising edge, the port granted a read that cycle, or NONE when no read is granted.
REQ-025 Read latency is exactly one cycle: a_rvalid = (rsel==A), b_rvalid = (rsel==B), asserted the cycle after the grant.
REQ-026 x_rdata equals mem_q while x_rvalid is high, otherwise 0.
REQ-027 A granted write produces no rvalid; a granted write sets rsel to NONE.
REQ-028 A port asserting req with a grant issued one cycle earlier is legal; its new grant and previous rvalid coincide.
REQ-029 Read-after-write to the same address on consecutive cycles returns the newly written data.
REQ-030 Requests with req low are ignored regardless of addr/we/wdata values.

Reset
REQ-031 While rst is high: a_gnt, b_gnt, a_rvalid, b_rvalid and mem_memw are 0; mem_addr, mem_data, a_rdata and b_rdata are 0.
REQ-032 At the reset edge rsel loads NONE, so a read granted in the cycle before reset never raises rvalid; the round-robin pointer resets so port A wins first contention.

Configuration
REQ-033 Macro MEM_ARBITER_RR_EN defined: on simultaneous requests, grant the port not granted most recently; the pointer updates on every grant.
REQ-034 MEM_ARBITER_RR_EN undefined: fixed priority, port B always wins contention; port A is granted only when b_req is low; no pointer register exists.

Verification
REQ-035 Reset, then a_req=1 with a_addr=0x005 for one cycle and memory word 5 = 0x1234 -> a_gnt=1 that cycle, next cycle a_rvalid=1 with a_rdata=0x1234, b_rvalid=0.
REQ-036 b_req=1, b_we=1, b_addr=0x010, b_wdata=0xBEEF; next cycle b read of 0x010 -> mem_memw=1 in cycle 1, b_rvalid=1 with b_rdata=0xBEEF in cycle 3, no rvalid in cycle 2.
REQ-037 a_req and b_req both high for 4 cycles, reads -> RR_EN: grants alternate A,B,A,B; without RR_EN: b_gnt all 4 cycles, a_gnt 0.
REQ-038 Port A grant at cycle N, rst high in cycle N+1 -> a_rvalid=0 in cycle N+1 and N+2, all outputs 0 during reset.
REQ-039 Port A streams reads of 0x000..0x003 on consecutive cycles, memory preloaded 0x00..0x03 -> a_gnt high 4 cycles, a_rvalid high 4 cycles delayed by one, data 0x0000..0x0003 in order.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction-fetch port A and load/store port B onto one synchronous 16-bit memory.
// Define MEM_ARBITER_RR_EN for round-robin contention; by default port B has fixed priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_a_req,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  output logic                  o_a_gnt,
  output logic                  o_a_rvalid,
  output logic [15:0]           o_a_rdata,
  input  logic                  i_b_req,
  input  logic                  i_b_we,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [15:0]           i_b_wdata,
  output logic                  o_b_gnt,
  output logic                  o_b_rvalid,
  output logic [15:0]           o_b_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [15:0]           o_mem_data,
  output logic                  o_mem_memw,
  input  logic [15:0]           i_mem_q
);

  typedef enum logic [1:0] {
    RSEL_NONE = 2'd0,
    RSEL_A    = 2'd1,
    RSEL_B    = 2'd2
  } rsel_t;

  rsel_t r_rsel;
  rsel_t w_rsel_nxt;
  logic  w_a_gnt;
  logic  w_b_gnt;
  logic  w_contend;

  assign w_contend = i_a_req & i_b_req;

`ifdef MEM_ARBITER_RR_EN
  logic r_last_a;

  // Pointer remembers the most recently granted port; reset favours A.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_a <= 1'b0;
    end else if (w_a_gnt) begin
      r_last_a <= 1'b1;
    end else if (w_b_gnt) begin
      r_last_a <= 1'b0;
    end else begin
      r_last_a <= r_last_a;
    end
  end
`endif

  // Combinational grant: lone requests win immediately, contention by policy.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (i_rst) begin
      w_a_gnt = 1'b0;
      w_b_gnt = 1'b0;
    end else if (w_contend) begin
`ifdef MEM_ARBITER_RR_EN
      w_a_gnt = ~r_last_a;
      w_b_gnt = r_last_a;
`else
      w_a_gnt = 1'b0;
      w_b_gnt = 1'b1;
`endif
    end else if (i_a_req) begin
      w_a_gnt = 1'b1;
    end else if (i_b_req) begin
      w_b_gnt = 1'b1;
    end else begin
      w_a_gnt = 1'b0;
      w_b_gnt = 1'b0;
    end
  end

  // Next read-return owner; writes and idle cycles return nothing.
  always_comb begin
    w_rsel_nxt = RSEL_NONE;
    if (w_b_gnt && !i_b_we) begin
      w_rsel_nxt = RSEL_B;
    end else if (w_a_gnt) begin
      w_rsel_nxt = RSEL_A;
    end else begin
      w_rsel_nxt = RSEL_NONE;
    end
  end

  // Read-return owner register, one cycle behind the grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsel <= RSEL_NONE;
    end else begin
      r_rsel <= w_rsel_nxt;
    end
  end

  // Memory-side request mux driven by the granted port.
  always_comb begin
    o_mem_addr = {ADDR_WIDTH{1'b0}};
    o_mem_data = 16'h0000;
    o_mem_memw = 1'b0;
    case ({w_a_gnt, w_b_gnt})
      2'b10: begin
        o_mem_addr = i_a_addr;
      end
      2'b01: begin
        o_mem_addr = i_b_addr;
        o_mem_data = i_b_wdata;
        o_mem_memw = i_b_we;
      end
      default: begin
        o_mem_addr = {ADDR_WIDTH{1'b0}};
        o_mem_data = 16'h0000;
        o_mem_memw = 1'b0;
      end
    endcase
  end

  // Read return: a read owner captured before reset must stay silent while reset is high.
  always_comb begin
    o_a_rvalid = 1'b0;
    o_b_rvalid = 1'b0;
    o_a_rdata  = 16'h0000;
    o_b_rdata  = 16'h0000;
    if (i_rst) begin
      o_a_rvalid = 1'b0;
      o_b_rvalid = 1'b0;
    end else begin
      case (r_rsel)
        RSEL_A: begin
          o_a_rvalid = 1'b1;
          o_a_rdata  = i_mem_q;
        end
        RSEL_B: begin
          o_b_rvalid = 1'b1;
          o_b_rdata  = i_mem_q;
        end
        default: begin
          o_a_rvalid = 1'b0;
          o_b_rvalid = 1'b0;
        end
      endcase
    end
  end

  assign o_a_gnt = w_a_gnt;
  assign o_b_gnt = w_b_gnt;

endmodule
